// File: rtl/lab2_serial_bls_ctrl.sv
// Serial WIDTH-bit subtractor controller: drives one external 4-bit borrow-lookahead
// subtractor a nibble per clock (LSB first), chaining the borrow and assembling the result.
module lab2_serial_bls_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic [3:0]       sub_X,
  output logic [3:0]       sub_Y,
  output logic             sub_Bin,
  input  logic [3:0]       sub_Diff,
  input  logic             sub_Bout
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] x_l;
  logic [WIDTH-1:0] y_l;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic             last;

  assign last = (state == S_RUN) && (idx == LAST_IDX);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result word with the current nibble merged in
  always_comb begin
    work_nxt = work;
    work_nxt[4*int'(idx) +: 4] = sub_Diff;
  end

  // x_l/y_l hold the not-yet-presented nibbles, so sub_X/sub_Y/sub_Bin can be
  // registered and already show the current nibble during each RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      x_l     <= '0;
      y_l     <= '0;
      work    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Diff    <= '0;
      Bout    <= 1'b0;
      sub_X   <= 4'h0;
      sub_Y   <= 4'h0;
      sub_Bin <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_l     <= X >> 4;
            y_l     <= Y >> 4;
            sub_X   <= X[3:0];
            sub_Y   <= Y[3:0];
            sub_Bin <= Bin;
            idx     <= '0;
            work    <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          work <= work_nxt;
          x_l  <= x_l >> 4;
          y_l  <= y_l >> 4;
          if (last) begin
            Diff    <= work_nxt;
            Bout    <= sub_Bout;
            busy    <= 1'b0;
            done    <= 1'b1;
            idx     <= '0;
            sub_X   <= 4'h0;
            sub_Y   <= 4'h0;
            sub_Bin <= 1'b0;
          end else begin
            idx     <= idx + 1'b1;
            sub_X   <= x_l[3:0];
            sub_Y   <= y_l[3:0];
            sub_Bin <= sub_Bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_serial_bls_ctrl.sv
// Bench for lab2_serial_bls_ctrl with a behavioural 4-bit borrow-lookahead subtractor.
module tb_lab2_serial_bls_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic [3:0]       sub_X;
  logic [3:0]       sub_Y;
  logic             sub_Bin;
  logic [3:0]       sub_Diff;
  logic             sub_Bout;
  logic [4:0]       sub_full;

  int n_vec  = 0;
  int n_fail = 0;

  lab2_serial_bls_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .X        (X),
    .Y        (Y),
    .Bin      (Bin),
    .busy     (busy),
    .done     (done),
    .Diff     (Diff),
    .Bout     (Bout),
    .sub_X    (sub_X),
    .sub_Y    (sub_Y),
    .sub_Bin  (sub_Bin),
    .sub_Diff (sub_Diff),
    .sub_Bout (sub_Bout)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit subtractor: 5-bit difference, top bit is the borrow
  assign sub_full = {1'b0, sub_X} - {1'b0, sub_Y} - 5'(sub_Bin);
  assign sub_Diff = sub_full[3:0];
  assign sub_Bout = sub_full[4];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic [15:0] exp_diff;
    logic        exp_bout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full operation: checks every RUN cycle, the done cycle and the cycle after.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic b,
                        input logic [15:0] ed, input logic eb, output logic [3:0] bseq);
    logic [15:0] prev_diff;
    logic [3:0]  xn;
    logic [3:0]  yn;
    prev_diff = Diff;
    @(posedge clk); #1;
    X = x; Y = y; Bin = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    X = ~x; Y = x ^ y; Bin = ~b;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      xn = x[4*k +: 4];
      yn = y[4*k +: 4];
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("sub_x_run", 32'(sub_X), 32'(xn));
      chk("sub_y_run", 32'(sub_Y), 32'(yn));
      chk("diff_hold", 32'(Diff), 32'(prev_diff));
      bseq[k] = sub_Bin;
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("diff", 32'(Diff), 32'(ed));
    chk("bout", 32'(Bout), 32'(eb));
    chk("sub_idle", {23'd0, sub_X, sub_Y, sub_Bin}, 32'd0);
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("diff_keep", 32'(Diff), 32'(ed));
  endtask

  initial begin
    logic [3:0]  bs;
    logic [15:0] sav;
    int          ndone;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{16'hBBBB, 16'hBBBB, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
    vecs[7] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0};

    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_bout", 32'(Bout), 32'd0);
    chk("rst_sub", {23'd0, sub_X, sub_Y, sub_Bin}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout, bs);
      if (i == 1) chk("sub_bin_seq", 32'(bs), 32'(4'b1110));
    end

    // Start pulsed during RUN with other operands: ignored
    @(posedge clk); #1;
    X = 16'h1234; Y = 16'h0234; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    X = 16'hFFFF; Y = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ignore_diff", 32'(Diff), 32'h1000);
        chk("ignore_bout", 32'(Bout), 32'd0);
      end
    end
    chk("ignore_ndone", 32'(ndone), 32'd1);
    chk("ignore_busy", 32'(busy), 32'd0);

    // Reset in cycle 2 of RUN aborts and clears results
    sav = 16'hBEEF;
    @(posedge clk); #1;
    X = sav; Y = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(Diff), 32'd0);
    chk("arst_bout", 32'(Bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("arst_no_done", 32'(ndone), 32'd0);
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, bs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
